// File: rtl/vga_fetch_sched.sv
// rtl/vga_fetch_sched.sv - frame-synchronised framebuffer burst fetch scheduler feeding the VGA pixel FIFO
// Optional double buffering selected by defining VGA_FETCH_DOUBLE_BUFFER_EN.
module vga_fetch_sched #(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 256,
  parameter int ADDR_W     = 32,
  parameter int BASE_ADDR  = 0,
  parameter int BUF_STRIDE = HDISP*VDISP*4
) (
  input  logic                            pixel_clk,
  input  logic                            pixel_rst,
  input  logic                            frame_start,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            fifo_wr,
  output logic [31:0]                     fifo_wdata,
  output logic                            mem_req,
  output logic [ADDR_W-1:0]               mem_addr,
  input  logic                            mem_ack,
  input  logic                            mem_rvalid,
  input  logic [31:0]                     mem_rdata,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            buf_sel
);
  localparam int NBURST = HDISP*VDISP/BURST_LEN;
  localparam int BCNT_W = $clog2(NBURST+1);
  localparam int BEAT_W = $clog2(BURST_LEN+1);
  localparam int LVL_W  = $clog2(FIFO_DEPTH+1);
  localparam logic [ADDR_W-1:0] BASE0       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN*4);
  localparam logic [LVL_W-1:0]  LVL_MAX     = LVL_W'(FIFO_DEPTH-BURST_LEN);
  localparam logic [BCNT_W-1:0] LAST_BURST  = BCNT_W'(NBURST-1);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN-1);

  typedef enum logic [2:0] {IDLE, WAIT_SPACE, REQ, BURST, DONE} state_t;

  state_t              r_state;
  logic [BCNT_W-1:0]   r_burst;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_pending;
  logic                r_fifo_wr;
  logic [31:0]         r_fifo_wdata;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_busy;
  logic                r_frame_done;

  logic                w_beat;
  logic                w_last_beat;
  logic                w_space;
  logic                w_restart;
  logic [ADDR_W-1:0]   w_next_base;

  assign w_beat      = (r_state == BURST) && mem_rvalid;
  assign w_last_beat = w_beat && (r_beat == LAST_BEAT);
  assign w_space     = (fifo_level <= LVL_MAX);

  // A frame_start seen mid-burst is deferred until the last beat lands.
  assign w_restart = (frame_start && ((r_state == IDLE) || (r_state == DONE) ||
                                      (r_state == WAIT_SPACE) || ((r_state == REQ) && !mem_ack)))
                   || (w_last_beat && (r_pending || frame_start));

`ifdef VGA_FETCH_DOUBLE_BUFFER_EN
  localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(BASE_ADDR + BUF_STRIDE);
  logic r_first;
  logic r_buf_sel;
  logic w_next_buf;

  // The first frame after reset always scans buffer 0; later restarts alternate.
  assign w_next_buf  = r_first ? 1'b0 : ~r_buf_sel;
  assign w_next_base = w_next_buf ? BASE1 : BASE0;
  assign buf_sel     = r_buf_sel;

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst) begin
      r_first   <= 1'b1;
      r_buf_sel <= 1'b0;
    end else if (w_restart) begin
      r_first   <= 1'b0;
      r_buf_sel <= w_next_buf;
    end
  end
`else
  assign w_next_base = BASE0;
  assign buf_sel     = 1'b0;
`endif

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst) begin
      r_state      <= IDLE;
      r_burst      <= '0;
      r_beat       <= '0;
      r_pending    <= 1'b0;
      r_fifo_wr    <= 1'b0;
      r_fifo_wdata <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= BASE0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_fifo_wr <= w_beat;
      if (w_beat) r_fifo_wdata <= mem_rdata;
      if (w_restart) begin
        r_state      <= WAIT_SPACE;
        r_mem_addr   <= w_next_base;
        r_burst      <= '0;
        r_beat       <= '0;
        r_pending    <= 1'b0;
        r_mem_req    <= 1'b0;
        r_busy       <= 1'b1;
        r_frame_done <= 1'b0;
      end else begin
        case (r_state)
          WAIT_SPACE: if (w_space) begin
            r_state   <= REQ;
            r_mem_req <= 1'b1;
          end
          REQ: if (mem_ack) begin
            r_state   <= BURST;
            r_mem_req <= 1'b0;
            r_beat    <= '0;
            if (frame_start) r_pending <= 1'b1;
          end
          BURST: begin
            if (frame_start) r_pending <= 1'b1;
            if (w_beat) begin
              r_beat <= r_beat + 1'b1;
              if (w_last_beat) begin
                r_mem_addr <= r_mem_addr + BURST_BYTES;
                r_burst    <= r_burst + 1'b1;
                if (r_burst == LAST_BURST) begin
                  r_state      <= DONE;
                  r_frame_done <= 1'b1;
                  r_busy       <= 1'b0;
                end else begin
                  r_state <= WAIT_SPACE;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign fifo_wr    = r_fifo_wr;
  assign fifo_wdata = r_fifo_wdata;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_vga_fetch_sched.sv
// tb/tb_vga_fetch_sched.sv - randomized directed bench for vga_fetch_sched against a frame-level reference model
module tb_vga_fetch_sched;
  localparam int HD = 16, VD = 4, BL = 16, FD = 256, AW = 32;
  localparam int BASE = 0;
  localparam int STRIDE = HD*VD*4;
  localparam int NB = HD*VD/BL;
  localparam int LW = $clog2(FD+1);

  logic          pixel_clk = 1'b0;
  logic          pixel_rst = 1'b0;
  logic          frame_start = 1'b0;
  logic [LW-1:0] fifo_level = '0;
  logic          mem_ack = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          fifo_wr;
  logic [31:0]   fifo_wdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          busy, frame_done, buf_sel;

  int checks = 0;
  int failures = 0;
  bit exp_buf = 1'b0;
  bit first = 1'b1;

  always #5 pixel_clk = ~pixel_clk;

  vga_fetch_sched #(.HDISP(HD), .VDISP(VD), .BURST_LEN(BL), .FIFO_DEPTH(FD),
                    .ADDR_W(AW), .BASE_ADDR(BASE), .BUF_STRIDE(STRIDE)) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .frame_start(frame_start),
    .fifo_level(fifo_level), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy),
    .frame_done(frame_done), .buf_sel(buf_sel)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  function automatic logic [AW-1:0] base_addr();
    return AW'(BASE) + (exp_buf ? AW'(STRIDE) : AW'(0));
  endfunction

  task automatic restart_model();
    if (first) first = 1'b0;
    else begin
`ifdef VGA_FETCH_DOUBLE_BUFFER_EN
      exp_buf = ~exp_buf;
`endif
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_fifo_wr"}, fifo_wr, 0);
    chk({tag, "_fifo_wdata"}, fifo_wdata, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_addr"}, mem_addr, BASE);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_buf_sel"}, buf_sel, 0);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    restart_model();
    tick();
    frame_start = 1'b0;
    chk("restart_addr", mem_addr, base_addr());
    chk("restart_busy", busy, 1);
    chk("restart_done", frame_done, 0);
    chk("restart_buf", buf_sel, exp_buf);
    chk("restart_req", mem_req, 0);
  endtask

  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin ok = 1'b1; break; end
      tick();
    end
    chk("req_seen", ok, 1);
  endtask

  // fs_beat: -1 none, -2 on the ack cycle, >=0 on that beat index
  task automatic run_burst(input logic [AW-1:0] addr, input int ack_delay, input int fs_beat, input bit last);
    logic [31:0] d;
    int n = 0;
    wait_req();
    chk("req_addr", mem_addr, addr);
    for (int i = 0; i < ack_delay; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata = $urandom;
      tick();
      chk("req_hold", mem_req, 1);
      chk("addr_hold", mem_addr, addr);
      chk("no_wr_in_req", fifo_wr, 0);
    end
    mem_rvalid = 1'b0;
    mem_ack = 1'b1;
    frame_start = (fs_beat == -2);
    tick();
    mem_ack = 1'b0;
    frame_start = 1'b0;
    chk("req_drop", mem_req, 0);
    for (int c = 0; n < BL && c < 200; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'b0;
        tick();
        chk("gap_no_wr", fifo_wr, 0);
      end else begin
        d = $urandom;
        mem_rvalid = 1'b1;
        mem_rdata = d;
        frame_start = (n == fs_beat);
        tick();
        frame_start = 1'b0;
        chk("beat_wr", fifo_wr, 1);
        chk("beat_data", fifo_wdata, d);
        n++;
      end
    end
    mem_rvalid = 1'b0;
    chk("beat_count", n, BL);
    if (fs_beat != -1) begin
      restart_model();
      chk("pend_addr", mem_addr, base_addr());
      chk("pend_buf", buf_sel, exp_buf);
      chk("pend_done", frame_done, 0);
    end else begin
      chk("next_addr", mem_addr, addr + AW'(BL*4));
      chk("frame_done", frame_done, last);
      chk("busy_after", busy, !last);
    end
    mem_rvalid = 1'b1;
    mem_rdata = $urandom;
    tick();
    mem_rvalid = 1'b0;
    chk("stray_no_wr", fifo_wr, 0);
    if (last && fs_beat == -1) chk("done_no_req", mem_req, 0);
  endtask

  task automatic run_frame(input int fs_burst, input int fs_beat, input int slow_burst);
    logic [AW-1:0] lb = base_addr();
    for (int k = 0; k < NB; k++) begin
      run_burst(lb + AW'(k*BL*4), (k == slow_burst) ? 5 : int'($urandom_range(0, 3)),
                (k == fs_burst) ? fs_beat : -1, k == NB-1);
      if (k == fs_burst) break;
    end
  endtask

  initial begin
    #1;
    tick();
    tick();
    reset_checks("reset");
    pixel_rst = 1'b1;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("idle_stray", fifo_wr, 0);
    chk("idle_busy", busy, 0);

    pulse_fs();
    run_frame(-1, -1, 1);

    fifo_level = LW'(241);
    pulse_fs();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("full_no_req", mem_req, 0);
      chk("full_busy", busy, 1);
    end
    pulse_fs();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_no_req2", mem_req, 0);
    end
    fifo_level = LW'(240);
    tick();
    if (!mem_req) tick();
    chk("space_req", mem_req, 1);
    pulse_fs();
    fifo_level = '0;
    run_frame(-1, -1, -1);

    pulse_fs();
    run_frame(1, 7, -1);
    run_frame(-1, -1, 0);

    pulse_fs();
    run_frame(0, -2, -1);
    run_frame(-1, -1, -1);

    pulse_fs();
    wait_req();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata = $urandom;
      tick();
    end
    pixel_rst = 1'b0;
    tick();
    pixel_rst = 1'b1;
    first = 1'b1;
    exp_buf = 1'b0;
    reset_checks("midrst");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_wr", fifo_wr, 0);
      chk("post_rst_no_req", mem_req, 0);
      chk("post_rst_busy", busy, 0);
    end
    mem_rvalid = 1'b0;
    pulse_fs();
    run_frame(-1, -1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
